// File: rtl/uart_rx_data_unit.sv
// UART receive datapath: oversampled start-bit qualification, LSB-first shift-in,
// stop-bit check and a READY/DATA_ACK handshake with framing and overrun flags.
module uart_rx_data_unit #(
  parameter int WORD_SIZE       = 8,
  parameter int SAMPLES_PER_BIT = 8
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 SERIAL_IN,
  input  logic                 DATA_ACK,
  output logic [WORD_SIZE-1:0] RCV_DATAREG,
  output logic                 READY,
  output logic                 ERROR_FRAME,
  output logic                 ERROR_OVERRUN
);

  localparam int SCW = $clog2(SAMPLES_PER_BIT);
  localparam int BCW = $clog2(WORD_SIZE + 1);
  localparam logic [SCW-1:0] SC_HALF = SCW'(SAMPLES_PER_BIT / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(SAMPLES_PER_BIT - 1);
  localparam logic [BCW-1:0] BC_STOP = BCW'(WORD_SIZE);

  typedef enum logic [1:0] {IDLE, STARTING, RECEIVING} state_e;

  state_e               state_q, state_d;
  logic [SCW-1:0]       sample_cnt_q, sample_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WORD_SIZE-1:0] shft_q, shft_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 sample_pt;
  logic                 stop_pt;

  assign sample_pt = (state_q == RECEIVING) && (sample_cnt_q == SC_LAST);
  assign stop_pt   = sample_pt && (bit_cnt_q == BC_STOP);

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shft_q       <= '0;
      data_q       <= '0;
      ready_q      <= 1'b0;
      ferr_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shft_q       <= shft_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
      ferr_q       <= ferr_d;
      ovr_q        <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!SERIAL_IN) state_d = STARTING;
      STARTING: begin
        if (SERIAL_IN)                   state_d = IDLE;
        else if (sample_cnt_q == SC_HALF) state_d = RECEIVING;
      end
      RECEIVING: if (stop_pt) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shft_d       = shft_q;
    data_d       = data_q;
    ready_d      = ready_q;
    ferr_d       = ferr_q;
    ovr_d        = ovr_q;
    case (state_q)
      IDLE: if (!SERIAL_IN) sample_cnt_d = SCW'(1);
      STARTING: begin
        if (!SERIAL_IN) begin
          if (sample_cnt_q == SC_HALF) begin
            sample_cnt_d = '0;
            bit_cnt_d    = '0;
          end else begin
            sample_cnt_d = sample_cnt_q + SCW'(1);
          end
        end
      end
      RECEIVING: begin
        if (sample_pt) begin
          sample_cnt_d = '0;
          if (bit_cnt_q != BC_STOP) begin
            shft_d    = {SERIAL_IN, shft_q[WORD_SIZE-1:1]};
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end else begin
          sample_cnt_d = sample_cnt_q + SCW'(1);
        end
      end
      default: ;
    endcase
    // A completion wins over an acknowledge; the ack then only suppresses overrun.
    if (stop_pt) begin
      data_d  = shft_q;
      ready_d = 1'b1;
      ferr_d  = ~SERIAL_IN;
      ovr_d   = ready_q & ~DATA_ACK;
    end else if (DATA_ACK) begin
      ready_d = 1'b0;
    end
  end

  assign RCV_DATAREG   = data_q;
  assign READY         = ready_q;
  assign ERROR_FRAME   = ferr_q;
  assign ERROR_OVERRUN = ovr_q;

endmodule

// File: tb/tb_uart_rx_data_unit.sv
// Bench for uart_rx_data_unit: directed and random frames on an 8x and a 4x
// oversampled instance, checked against a frame-level model of the receiver.
module tb_uart_rx_data_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ser_a [2];
  logic       ack_a [2];
  logic [7:0] dat_a [2];
  logic       rdy_a [2];
  logic       fe_a  [2];
  logic       oe_a  [2];

  logic [7:0] m_dat [2];
  logic       m_rdy [2];
  logic       m_fe  [2];
  logic       m_oe  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_data_unit #(.WORD_SIZE(8), .SAMPLES_PER_BIT(8)) dut8 (
    .CLOCK(clk), .RESET(rst_n), .SERIAL_IN(ser_a[0]), .DATA_ACK(ack_a[0]),
    .RCV_DATAREG(dat_a[0]), .READY(rdy_a[0]), .ERROR_FRAME(fe_a[0]),
    .ERROR_OVERRUN(oe_a[0])
  );

  uart_rx_data_unit #(.WORD_SIZE(8), .SAMPLES_PER_BIT(4)) dut4 (
    .CLOCK(clk), .RESET(rst_n), .SERIAL_IN(ser_a[1]), .DATA_ACK(ack_a[1]),
    .RCV_DATAREG(dat_a[1]), .READY(rdy_a[1]), .ERROR_FRAME(fe_a[1]),
    .ERROR_OVERRUN(oe_a[1])
  );

  function automatic int spb_of(input int w);
    return (w == 0) ? 8 : 4;
  endfunction

  // Stop sample offset from the first low edge of the frame.
  function automatic int stop_off(input int w);
    return spb_of(w) / 2 - 1 + 9 * spb_of(w);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_dat[i] = 8'h00;
      m_rdy[i] = 1'b0;
      m_fe[i]  = 1'b0;
      m_oe[i]  = 1'b0;
    end
  endtask

  task automatic check_all(input int w, input string tag);
    chk({tag, ".data"},    dat_a[w], m_dat[w]);
    chk({tag, ".ready"},   {7'd0, rdy_a[w]}, {7'd0, m_rdy[w]});
    chk({tag, ".frame"},   {7'd0, fe_a[w]},  {7'd0, m_fe[w]});
    chk({tag, ".overrun"}, {7'd0, oe_a[w]},  {7'd0, m_oe[w]});
  endtask

  task automatic idle(input int w, input int n);
    ser_a[w] = 1'b1;
    ack_a[w] = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle.ready", {7'd0, rdy_a[w]}, {7'd0, m_rdy[w]});
    end
  endtask

  task automatic ack_pulse(input int w);
    ack_a[w] = 1'b1;
    step();
    ack_a[w] = 1'b0;
    m_rdy[w] = 1'b0;
    check_all(w, "ack");
  endtask

  // Drives one frame with bit-aligned timing. ack_c / rst_c pick the cycle (edge
  // offset from the first low edge) at which DATA_ACK or RESET is applied; -1 = never.
  task automatic send_frame(input int w, input logic [7:0] d, input logic stopb,
                            input int ack_c, input int rst_c);
    int spb = spb_of(w);
    int s   = stop_off(w);
    int n   = 10 * spb;
    for (int c = 0; c < n; c++) begin
      int b = c / spb;
      if (b == 0)       ser_a[w] = 1'b0;
      else if (b <= 8)  ser_a[w] = d[b-1];
      else              ser_a[w] = (c <= s) ? stopb : 1'b1;
      ack_a[w] = (c == ack_c);
      rst_n    = (c == rst_c) ? 1'b0 : 1'b1;
      step();
      if (c == rst_c) begin
        rst_n    = 1'b1;
        ack_a[w] = 1'b0;
        ser_a[w] = 1'b1;
        model_reset();
        check_all(w, "reset_mid");
        return;
      end
      if (c == s) begin
        m_oe[w]  = m_rdy[w] & ~ack_a[w];
        m_rdy[w] = 1'b1;
        m_dat[w] = d;
        m_fe[w]  = ~stopb;
        check_all(w, "stop");
      end else begin
        if (ack_a[w]) m_rdy[w] = 1'b0;
        chk("frame.ready", {7'd0, rdy_a[w]}, {7'd0, m_rdy[w]});
      end
    end
    ack_a[w] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ser_a[0] = 1'b1; ser_a[1] = 1'b1;
    ack_a[0] = 1'b0; ack_a[1] = 1'b0;
    rst_n    = 1'b0;
    repeat (3) step();
    model_reset();
    check_all(0, "reset8");
    check_all(1, "reset4");
    rst_n = 1'b1;
    idle(0, 5);

    // Basic frame and acknowledge.
    send_frame(0, 8'hA5, 1'b1, -1, -1);
    ack_pulse(0);
    idle(0, 3);
    check_all(0, "after_ack");

    // Short low glitch is rejected, then a clean frame.
    ser_a[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("glitch.ready", {7'd0, rdy_a[0]}, {7'd0, m_rdy[0]});
    end
    idle(0, 10);
    send_frame(0, 8'h3C, 1'b1, -1, -1);
    ack_pulse(0);

    // Framing error, then a good frame clears it.
    send_frame(0, 8'h3C, 1'b0, -1, -1);
    ack_pulse(0);
    send_frame(0, 8'h0F, 1'b1, -1, -1);
    ack_pulse(0);

    // Overrun, then the same pair with an ack in the stop-sample cycle.
    send_frame(0, 8'h11, 1'b1, -1, -1);
    send_frame(0, 8'h22, 1'b1, -1, -1);
    ack_pulse(0);
    send_frame(0, 8'h11, 1'b1, -1, -1);
    send_frame(0, 8'h22, 1'b1, stop_off(0), -1);

    // Reset during data bit 4 aborts the frame.
    send_frame(0, 8'h33, 1'b1, -1, 5 * 8 + 2);
    idle(0, 20);
    send_frame(0, 8'h5A, 1'b1, -1, -1);
    ack_pulse(0);

    // Back-to-back at 4x oversampling, acked during the next start bit.
    idle(1, 4);
    send_frame(1, 8'h00, 1'b1, -1, -1);
    send_frame(1, 8'hFF, 1'b1, 0, -1);
    ack_pulse(1);

    // Random frames on both instances.
    for (int k = 0; k < 24; k++) begin
      int         w    = k % 2;
      logic [7:0] d    = 8'($urandom);
      logic       sb   = ($urandom_range(0, 3) != 0);
      int         sel  = $urandom_range(0, 3);
      int         ac   = -1;
      if (sel == 1) ac = stop_off(w);
      if (sel == 2) ac = $urandom_range(0, 10 * spb_of(w) - 1);
      send_frame(w, d, sb, ac, -1);
      idle(w, $urandom_range(0, 2));
    end
    check_all(0, "final8");
    check_all(1, "final4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
